// File: rtl/execute_muldiv.sv
// -----------------------------------------------------------------------------
// execute_muldiv
//
// Iterative RISC-V M-extension unit. It covers MUL, MULH, MULHSU, MULHU, DIV,
// DIVU, REM and REMU. Signed operands are converted to magnitudes at accept.
// The unit then runs an unsigned shift-add multiply or a restoring divide,
// retiring STEP bits per CALC cycle. The sign of the result is fixed on entry
// to DONE. Divide-by-zero and signed overflow skip CALC and go straight to
// DONE with the architecturally defined result.
//
// Ports
//   clk_i           clock, all state updates on the rising edge
//   rst_i           synchronous active-high reset
//   flush_i         abort any in-flight operation and drop a pending result
//   valid_i         request valid; accepted when valid_i && ready_o
//   ready_o         unit idle and not being flushed
//   op_i            funct3 opcode (000 MUL ... 111 REMU)
//   rs1_i, rs2_i    XLEN-bit operands
//   rd_addr_i       destination tag captured at accept
//   result_valid_o  result held in DONE
//   result_ready_i  consumer takes the result
//   result_o        result (zero outside DONE)
//   rd_addr_o       tag of the operation being returned
//   busy_o          high in CALC or DONE, used to stall the pipeline
// -----------------------------------------------------------------------------
module execute_muldiv #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_addr_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            busy_o
);

  if ((XLEN % STEP) != 0) begin : g_step_check
    $error("execute_muldiv: XLEN must be a multiple of STEP");
  end

  localparam int NCYC  = XLEN / STEP;
  localparam int CNT_W = $clog2(NCYC + 1);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [2:0]       r_op;
  logic             r_neg;      // final result must be negated
  logic [XLEN-1:0]  r_hi;       // product high half / partial remainder
  logic [XLEN-1:0]  r_lo;       // multiplier then product low half / dividend then quotient
  logic [XLEN-1:0]  r_b;        // multiplicand / divisor magnitude
  logic [4:0]       r_rd_addr;
  logic             r_valid;
  logic [XLEN-1:0]  r_result;

  // ---------------------------------------------------------------------------
  // Accept-side decode: operand magnitudes, result sign, bypass cases
  // ---------------------------------------------------------------------------
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_neg;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_bypass;
  logic [XLEN-1:0] w_bypass_res;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    w_a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    w_b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    w_a_neg    = w_a_signed && rs1_i[XLEN-1];
    w_b_neg    = w_b_signed && rs2_i[XLEN-1];
    w_a_mag    = w_a_neg ? -rs1_i : rs1_i;
    w_b_mag    = w_b_neg ? -rs2_i : rs2_i;
    // A remainder takes the dividend's sign; everything else takes the product of the signs.
    w_neg      = (op_i == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_div_zero = op_i[2] && (rs2_i == '0);
    w_div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) && (rs1_i == MOST_NEG) && (rs2_i == '1);
    w_bypass   = w_div_zero || w_div_ovf;
    // op_i[1] separates REM/REMU from DIV/DIVU.
    w_bypass_res = '0;
    if (w_div_zero) w_bypass_res = op_i[1] ? rs1_i : '1;
    else if (w_div_ovf) w_bypass_res = op_i[1] ? '0 : rs1_i;
  end

  // ---------------------------------------------------------------------------
  // Datapath: STEP iterations of shift-add or restoring subtract per cycle
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rem_sh;

  always_comb begin
    w_hi     = r_hi;
    w_lo     = r_lo;
    w_sum    = '0;
    w_rem_sh = '0;
    // NOTE: blocking assignments are deliberate here; each loop pass must see
    // the value the previous pass produced.
    for (int i = 0; i < STEP; i++) begin
      if (r_op[2]) begin
        w_rem_sh = {w_hi, w_lo[XLEN-1]};
        w_lo     = {w_lo[XLEN-2:0], 1'b0};
        if (w_rem_sh >= {1'b0, r_b}) begin
          w_rem_sh = w_rem_sh - {1'b0, r_b};
          w_lo[0]  = 1'b1;
        end
        w_hi = w_rem_sh[XLEN-1:0];
      end else begin
        w_sum        = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : '0);
        {w_hi, w_lo} = {w_sum, w_lo[XLEN-1:1]};
      end
    end
  end

  // Sign correction applied to the last iteration's value as it enters DONE.
  // The high half of -{hi,lo} is ~hi plus the borrow out of the zero-check on lo.
  logic [XLEN-1:0] w_neg_hi;
  logic [XLEN-1:0] w_final;

  always_comb begin
    w_neg_hi = ~w_hi + XLEN'(w_lo == '0);
    w_final  = '0;
    case (r_op)
      OP_MUL:                       w_final = w_lo;
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = r_neg ? w_neg_hi : w_hi;
      OP_DIV, OP_DIVU:              w_final = r_neg ? -w_lo : w_lo;
      default:                      w_final = r_neg ? -w_hi : w_hi;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_op      <= '0;
      r_neg     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_rd_addr <= '0;
      r_valid   <= 1'b0;
      r_result  <= '0;
    end else if (flush_i) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_op      <= op_i;
            r_neg     <= w_neg;
            r_rd_addr <= rd_addr_i;
            r_hi      <= '0;
            r_lo      <= op_i[2] ? w_a_mag : w_b_mag;
            r_b       <= op_i[2] ? w_b_mag : w_a_mag;
            if (w_bypass) begin
              r_state  <= S_DONE;
              r_count  <= '0;
              r_valid  <= 1'b1;
              r_result <= w_bypass_res;
            end else begin
              r_state  <= S_CALC;
              r_count  <= CNT_W'(NCYC);
            end
          end
        end
        S_CALC: begin
          r_hi    <= w_hi;
          r_lo    <= w_lo;
          r_count <= r_count - 1'b1;
          if (r_count == CNT_W'(1)) begin
            r_state  <= S_DONE;
            r_valid  <= 1'b1;
            r_result <= w_final;
          end
        end
        S_DONE: begin
          if (result_ready_i) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_result <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A handoff cycle is still DONE, so no accept can coincide with it.
  assign ready_o        = (r_state == S_IDLE) && !flush_i;
  assign busy_o         = (r_state != S_IDLE);
  assign result_valid_o = r_valid;
  assign result_o       = r_result;
  assign rd_addr_o      = r_rd_addr;

endmodule

// File: tb/tb_execute_muldiv.sv
// -----------------------------------------------------------------------------
// tb_execute_muldiv
//
// Scoreboard bench for execute_muldiv. Stimulus pushes the reference result
// and tag into a queue at issue time. A negedge monitor pops an entry and
// compares it on every delivered result. The reference model uses plain
// 64-bit arithmetic. Two instances are used: STEP=1 and STEP=4.
// -----------------------------------------------------------------------------
module tb_execute_muldiv;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // STEP=1 instance
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b1;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        busy_o;

  // STEP=4 instance
  logic        flush4 = 1'b0;
  logic        valid4 = 1'b0;
  logic        ready4;
  logic [2:0]  op4 = '0;
  logic [31:0] rs1_4 = '0;
  logic [31:0] rs2_4 = '0;
  logic [4:0]  rd4 = '0;
  logic        rvalid4;
  logic        rready4 = 1'b1;
  logic [31:0] result4;
  logic [4:0]  rd_out4;
  logic        busy4;

  execute_muldiv #(.XLEN(XLEN), .STEP(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_addr_i(rd_addr_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_o(result_o), .rd_addr_o(rd_addr_o), .busy_o(busy_o)
  );

  execute_muldiv #(.XLEN(XLEN), .STEP(4)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush4), .valid_i(valid4), .ready_o(ready4),
    .op_i(op4), .rs1_i(rs1_4), .rs2_i(rs2_4), .rd_addr_i(rd4),
    .result_valid_o(rvalid4), .result_ready_i(rready4),
    .result_o(result4), .rd_addr_o(rd_out4), .busy_o(busy4)
  );

  exp_t q[$];
  exp_t q4[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   bp_mode = 0;   // 0: consumer always ready, 1: random, 2: driven by the test

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout/unexpected event, expected none (t=%0t)", name, $time);
  endtask

  // Reference behaviour from the instruction definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] up;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    up  = 64'(a) * 64'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: return up[31:0];
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: return up[63:32];
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Divide by zero and signed overflow skip the iterations.
  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
    logic byp;
    byp = op[2] && ((b == 0) || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return byp ? 1 : n + 1;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Consumer backpressure driver.
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_mode == 0) result_ready_i = 1'b1;
    else if (bp_mode == 1) result_ready_i = 1'($urandom_range(0, 1));
  end

  // Monitors: pop and compare on every delivered result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_i) begin
      if (!result_valid_o) check("result_o zero outside DONE", result_o, 32'd0);
      else if (result_ready_i && !flush_i) begin
        if (q.size() == 0) fail("unexpected result");
        else begin
          e = q.pop_front();
          check("result", result_o, e.res);
          check("rd_addr", 32'(rd_addr_o), 32'(e.rd));
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_i && rvalid4 && rready4) begin
      if (q4.size() == 0) fail("step4 unexpected result");
      else begin
        e = q4.pop_front();
        check("step4 result", result4, e.res);
        check("step4 rd_addr", 32'(rd_out4), 32'(e.rd));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input bit push);
    int   guard;
    exp_t e;
    guard = 0;
    while (!ready_o && guard < 500) begin @(posedge clk); #1; guard++; end
    if (!ready_o) begin fail("accept wait"); return; end
    op_i = op; rs1_i = a; rs2_i = b; rd_addr_i = tag; valid_i = 1'b1;
    if (push) begin
      e.res = ref_model(op, a, b);
      e.rd  = tag;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  // Counts negedges until result_valid_o is seen; returns on that negedge.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!result_valid_o && lat < 100);
    if (!result_valid_o) fail("result wait");
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int lat;
    issue(op, a, b, tag, 1'b1);
    wait_valid(lat);
    check("latency", lat, exp_lat(op, a, b, 32));
    @(posedge clk);
    #1;
  endtask

  task automatic run4(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int   lat, guard;
    exp_t e;
    guard = 0;
    while (!ready4 && guard < 100) begin @(posedge clk); #1; guard++; end
    if (!ready4) begin fail("step4 accept wait"); return; end
    op4 = op; rs1_4 = a; rs2_4 = b; rd4 = tag; valid4 = 1'b1;
    e.res = ref_model(op, a, b);
    e.rd  = tag;
    q4.push_back(e);
    @(posedge clk);
    #1;
    valid4 = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rvalid4 && lat < 100);
    check("step4 latency", lat, exp_lat(op, a, b, 8));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected the bench to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat, seen;
    logic [31:0] hold;

    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("reset ready_o", 32'(ready_o), 32'd1);
    check("reset result_valid_o", 32'(result_valid_o), 32'd0);
    check("reset result_o", result_o, 32'd0);
    check("reset rd_addr_o", 32'(rd_addr_o), 32'd0);
    check("reset busy_o", 32'(busy_o), 32'd0);
    check("reset step4 ready_o", 32'(ready4), 32'd1);
    @(posedge clk);
    #1;

    // Directed values
    run(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
    run(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd2);
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    run(3'd4, 32'h1234, 32'd0, 5'd4);
    run(3'd6, 32'h1234, 32'd0, 5'd6);
    run(3'd5, 32'h1234, 32'd0, 5'd7);
    run(3'd7, 32'h1234, 32'd0, 5'd8);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    run(3'd4, -32'd7, 32'd2, 5'd11);
    run(3'd6, -32'd7, 32'd2, 5'd12);
    run4(3'd4, -32'd7, 32'd2, 5'd13);
    run4(3'd6, -32'd7, 32'd2, 5'd14);

    // Backpressure: result held stable for five cycles, no accept meanwhile
    bp_mode = 2;
    result_ready_i = 1'b0;
    issue(3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF, 5'd21, 1'b1);
    wait_valid(lat);
    check("bp latency", lat, 33);
    hold = result_o;
    repeat (5) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp result stable", result_o, hold);
      check("bp ready_o low", 32'(ready_o), 32'd0);
      check("bp valid held", 32'(result_valid_o), 32'd1);
    end
    @(posedge clk);
    #1;
    result_ready_i = 1'b1;
    @(negedge clk);
    check("handoff ready_o low", 32'(ready_o), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("after handoff ready_o", 32'(ready_o), 32'd1);
    check("after handoff valid", 32'(result_valid_o), 32'd0);
    @(posedge clk);
    #1;

    // Flush in the tenth CALC cycle, with a simultaneous request
    bp_mode = 0;
    issue(3'd5, 32'hFFFF_0000, 32'd3, 5'd22, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    valid_i = 1'b1;
    @(negedge clk);
    check("flush ready_o low", 32'(ready_o), 32'd0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("post-flush ready_o", 32'(ready_o), 32'd1);
    check("post-flush busy_o", 32'(busy_o), 32'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (result_valid_o) seen++; end
    check("no result after flush", seen, 0);
    @(posedge clk);
    #1;

    // Flush wins over a handshake in DONE
    bp_mode = 2;
    result_ready_i = 1'b0;
    issue(3'd4, 32'h55, 32'd0, 5'd23, 1'b0);
    wait_valid(lat);
    @(posedge clk);
    #1;
    flush_i = 1'b1;
    result_ready_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush in DONE valid", 32'(result_valid_o), 32'd0);
    check("flush in DONE ready_o", 32'(ready_o), 32'd1);
    bp_mode = 0;
    @(posedge clk);
    #1;

    // Reset mid-CALC, overriding flush and valid
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd24, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    rst_i = 1'b1;
    flush_i = 1'b1;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("mid reset ready_o", 32'(ready_o), 32'd1);
    check("mid reset busy_o", 32'(busy_o), 32'd0);
    check("mid reset rd_addr_o", 32'(rd_addr_o), 32'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (result_valid_o) seen++; end
    check("no result after reset", seen, 0);
    @(posedge clk);
    #1;

    // Random traffic with random backpressure
    bp_mode = 1;
    for (int i = 0; i < 150; i++)
      run(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 5'($urandom_range(0, 31)));
    bp_mode = 0;
    for (int i = 0; i < 20; i++)
      run4(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 5'($urandom_range(0, 31)));

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard drained", q.size(), 0);
    check("step4 scoreboard drained", q4.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
